// File: rtl/dff_pattern_checker.sv
// Pattern checker for a single D flip-flop: LFSR stimulus on D, delayed compare of Q.
// Optional checker self-test input INJ is enabled by defining DFF_CHK_INJECT_EN.
module dff_pattern_checker #(
    parameter int         LEN   = 8,
    parameter logic [7:0] SEED  = 8'hA5,
    parameter int         CNT_W = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             START,
    input  logic             Q,
`ifdef DFF_CHK_INJECT_EN
    input  logic             INJ,
`endif
    output logic             D,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_FLUSH, ST_DONE} state_t;

    localparam logic [7:0] LAST_BIT = 8'(LEN - 1);

    state_t           state;
    logic [7:0]       lfsr;
    logic [7:0]       bit_cnt;
    logic             fb;
    logic             pattern_bit;
    logic             exp_p1;
    logic             vld_p1;
    logic             miss;
    logic [CNT_W-1:0] err_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != '1))
            return v + CNT_W'(1);
        return v;
    endfunction

    assign fb          = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4];
    assign pattern_bit = (state == ST_DRIVE) & lfsr[0];

    // Injection flips only the driven bit; the expected bit stays uninverted.
`ifdef DFF_CHK_INJECT_EN
    assign D = pattern_bit ^ ((state == ST_DRIVE) & INJ);
`else
    assign D = pattern_bit;
`endif

    // Stage p1: bit driven last cycle, now captured by the flop under test.
    assign miss     = vld_p1 && (Q != exp_p1);
    assign err_next = sat_inc(ERR_CNT, miss);

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state   <= ST_IDLE;
            lfsr    <= '0;
            bit_cnt <= '0;
            exp_p1  <= 1'b0;
            vld_p1  <= 1'b0;
            ERR_CNT <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            PASS    <= 1'b0;
        end else begin
            exp_p1  <= pattern_bit;
            vld_p1  <= (state == ST_DRIVE);
            ERR_CNT <= err_next;
            DONE    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        lfsr    <= SEED;
                        bit_cnt <= '0;
                        ERR_CNT <= '0;
                        PASS    <= 1'b0;
                        BUSY    <= 1'b1;
                        state   <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    lfsr    <= {fb, lfsr[7:1]};
                    bit_cnt <= bit_cnt + 8'd1;
                    if (bit_cnt == LAST_BIT)
                        state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    // The last bit is compared on this edge, so the verdict uses err_next.
                    PASS  <= (err_next == '0);
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_pattern_checker.sv
// Directed bench for dff_pattern_checker: loopback flop, stuck-at faults, reset, restart, saturation.
module tb_dff_pattern_checker;

    localparam logic [7:0] SEED = 8'hA5;
    localparam int         LEN  = 8;

    typedef struct {
        int   err;
        logic pass;
    } res_t;

    logic       c;
    logic       r;
    logic       start;
    logic       q;
    logic       flop_q;
    int         mode;
    logic       d, busy, done, pass;
    logic [7:0] err_cnt;
    logic       d_s, busy_s, done_s, pass_s;
    logic [1:0] err_s;
`ifdef DFF_CHK_INJECT_EN
    logic       inj;
`endif

    int   checks   = 0;
    int   failures = 0;
    logic exp_d_q[$];
    res_t res_q[$];

    dff_pattern_checker #(.LEN(LEN), .SEED(SEED), .CNT_W(8)) dut (
        .C(c), .R(r), .START(start), .Q(q),
`ifdef DFF_CHK_INJECT_EN
        .INJ(inj),
`endif
        .D(d), .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err_cnt)
    );

    dff_pattern_checker #(.LEN(LEN), .SEED(SEED), .CNT_W(2)) dut_sat (
        .C(c), .R(r), .START(start), .Q(q),
`ifdef DFF_CHK_INJECT_EN
        .INJ(inj),
`endif
        .D(d_s), .BUSY(busy_s), .DONE(done_s), .PASS(pass_s), .ERR_CNT(err_s)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    // Flop under test for loopback runs; mode 1/2 model stuck-at-0/1 outputs.
    always @(posedge c) flop_q <= d;
    assign q = (mode == 0) ? flop_q : (mode == 1) ? 1'b0 : 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive_run(input int m, input bit hold, input logic [7:0] mask);
        int   e;
        int   sat;
        logic b;
        res_t res;
        e     = 0;
        mode  = m;
        start = 1'b1;
        for (int i = 0; i < LEN; i++) begin
            exp_d_q.push_back(SEED[i] ^ mask[i]);
            if (m == 0)      e += int'(mask[i]);
            else if (m == 1) e += int'(SEED[i]);
            else             e += int'(!SEED[i]);
        end
        res_q.push_back('{e, (e == 0)});
        @(negedge c);
        if (!hold) start = 1'b0;
        check("clr_err", err_cnt, 0);
        check("clr_pass", pass, 0);
        for (int i = 0; i < LEN; i++) begin
`ifdef DFF_CHK_INJECT_EN
            inj = mask[i];
`endif
            b = exp_d_q.pop_front();
            check("d_bit", d, b);
            check("d_bit_sat", d_s, b);
            check("busy_drive", busy, 1);
            check("done_early", done, 0);
            @(negedge c);
        end
`ifdef DFF_CHK_INJECT_EN
        inj = 1'b0;
`endif
        check("d_flush", d, 0);
        check("busy_flush", busy, 1);
        check("busy_flush_sat", busy_s, 1);
        check("done_flush", done, 0);
        @(negedge c);
        res = res_q.pop_front();
        sat = (res.err > 3) ? 3 : res.err;
        check("done_pulse", done, 1);
        check("done_pulse_sat", done_s, 1);
        check("busy_done", busy, 0);
        check("err_cnt", err_cnt, res.err);
        check("pass", pass, res.pass);
        check("err_sat", err_s, sat);
        check("pass_sat", pass_s, res.pass);
        @(negedge c);
        check("done_once", done, 0);
        check("err_hold", err_cnt, res.err);
        check("pass_hold", pass, res.pass);
    endtask

    initial begin
        mode  = 0;
        start = 1'b0;
`ifdef DFF_CHK_INJECT_EN
        inj   = 1'b0;
`endif
        r     = 1'b1;
        repeat (2) @(negedge c);
        check("rst_d", d, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        r = 1'b0;
        @(negedge c);

        drive_run(0, 1'b0, 8'h00);
        drive_run(1, 1'b0, 8'h00);
        drive_run(2, 1'b0, 8'h00);

        drive_run(0, 1'b0, 8'h00);
        r = 1'b1;
        #1;
        check("rst_idle_pass", pass, 0);
        @(negedge c);
        r = 1'b0;
        @(negedge c);

        mode  = 1;
        start = 1'b1;
        @(negedge c);
        start = 1'b0;
        repeat (3) @(negedge c);
        check("mid_err", err_cnt, 1);
        check("mid_busy", busy, 1);
        check("mid_d", d, SEED[3]);
        r = 1'b1;
        #1;
        check("mid_rst_d", d, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_pass", pass, 0);
        check("mid_rst_err", err_cnt, 0);
        check("mid_rst_err_sat", err_s, 0);
        @(negedge c);
        r = 1'b0;
        @(negedge c);
        check("post_rst_err", err_cnt, 0);
        check("post_rst_busy", busy, 0);
        drive_run(0, 1'b0, 8'h00);

        drive_run(1, 1'b1, 8'h00);
        drive_run(0, 1'b0, 8'h00);

`ifdef DFF_CHK_INJECT_EN
        drive_run(0, 1'b0, 8'h04);
        drive_run(0, 1'b0, 8'hFF);
`endif

        repeat (2) @(negedge c);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
